// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side bus bundle shared by all sram_arbiter requesters
interface sram_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_lock;
    logic [4*NUM_REQ-1:0]  req_web;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    // Requester view: drives requests, receives grants and responses.
    modport master (
        output req_valid, req_lock, req_web, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Arbiter view.
    modport slave (
        input  req_valid, req_lock, req_web, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin SRAM arbiter with RMW byte writes, range filter and bus lock
module sram_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus,
    output logic [3:0]    sram_web,
    output logic [31:0]   sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    localparam logic [1:0] K_READ  = 2'd0;
    localparam logic [1:0] K_WRITE = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] r_rr_ptr;
    logic           r_lock_active;
    logic [IDW-1:0] r_lock_owner;

    logic [31:0]    r_rmw_addr;
    logic [31:0]    r_rmw_wdata;
    logic [3:0]     r_rmw_web;
    logic [IDW-1:0] r_rmw_id;

    logic           r_rsp_pend;
    logic [IDW-1:0] r_rsp_id;
    logic [1:0]     r_rsp_kind;

    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_id;
    logic [IDW:0]   w_sum;

    logic [3:0]     w_g_web;
    logic [31:0]    w_g_addr;
    logic [31:0]    w_g_wdata;
    logic           w_g_lock;
    logic           w_is_err;
    logic           w_is_read;
    logic           w_is_fwr;
    logic           w_is_pwr;
    logic [31:0]    w_merge;
    logic [IDW-1:0] w_rr_next;

    // Pick the winner: only the lock owner while locked, else first valid from rr_ptr upward.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        if (rst_n && (r_state == S_IDLE)) begin
            if (r_lock_active) begin
                if (bus.req_valid[r_lock_owner]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = r_lock_owner;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                    if (w_sum >= NREQ_W) begin
                        w_sum = w_sum - NREQ_W;
                    end
                    if (!w_gnt_any && bus.req_valid[w_sum[IDW-1:0]]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_id  = w_sum[IDW-1:0];
                    end
                end
            end
        end
    end

    // Select the granted payload and classify it; out-of-window addresses win over everything.
    always_comb begin
        w_g_web   = bus.req_web[w_gnt_id*4 +: 4];
        w_g_addr  = bus.req_addr[w_gnt_id*32 +: 32];
        w_g_wdata = bus.req_wdata[w_gnt_id*32 +: 32];
        w_g_lock  = bus.req_lock[w_gnt_id];
        w_is_err  = (w_g_addr[31:16] != 16'h0);
        w_is_read = !w_is_err && (w_g_web == 4'hF);
        w_is_fwr  = !w_is_err && (w_g_web == 4'h0);
        w_is_pwr  = !w_is_err && !w_is_read && !w_is_fwr;
        w_rr_next = (w_gnt_id == LAST_ID) ? '0 : (w_gnt_id + IDW'(1));
    end

    // Byte merge for the RMW write: enabled bytes from captured data, the rest from the old word.
    always_comb begin
        w_merge = '0;
        for (int k = 0; k < 4; k++) begin
            w_merge[8*k +: 8] = r_rmw_web[k] ? sram_rdata[8*k +: 8] : r_rmw_wdata[8*k +: 8];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a partial write spends one extra cycle in MERGE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_any && w_is_pwr) w_state_nxt = S_MERGE;
            S_MERGE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: grant and SRAM port; everything parks idle while in reset.
    always_comb begin
        bus.req_ready = '0;
        sram_web      = 4'hF;
        sram_addr     = 32'h0;
        sram_wdata    = 32'h0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        bus.req_ready[w_gnt_id] = 1'b1;
                        if (!w_is_err) begin
                            sram_addr = {w_g_addr[31:2], 2'b00};
                            if (w_is_fwr) begin
                                sram_web   = 4'h0;
                                sram_wdata = w_g_wdata;
                            end
                        end
                    end
                end
                S_MERGE: begin
                    sram_web   = 4'h0;
                    sram_addr  = r_rmw_addr;
                    sram_wdata = w_merge;
                end
                default: begin
                    sram_web = 4'hF;
                end
            endcase
        end
    end

    // Round-robin pointer and lock tracking; a locked owner does not advance the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_lock_active <= 1'b0;
            r_lock_owner  <= '0;
        end else if (w_gnt_any) begin
            if (!r_lock_active) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_g_lock) begin
                r_lock_active <= 1'b1;
                r_lock_owner  <= w_gnt_id;
            end else begin
                r_lock_active <= 1'b0;
            end
        end
    end

    // Capture the partial-write payload for the MERGE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rmw_addr  <= 32'h0;
            r_rmw_wdata <= 32'h0;
            r_rmw_web   <= 4'hF;
            r_rmw_id    <= '0;
        end else if (w_gnt_any && w_is_pwr) begin
            r_rmw_addr  <= {w_g_addr[31:2], 2'b00};
            r_rmw_wdata <= w_g_wdata;
            r_rmw_web   <= w_g_web;
            r_rmw_id    <= w_gnt_id;
        end
    end

    // Response register: loaded on a single-cycle transfer or on the MERGE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_pend <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_kind <= K_READ;
        end else begin
            r_rsp_pend <= 1'b0;
            if (r_state == S_MERGE) begin
                r_rsp_pend <= 1'b1;
                r_rsp_id   <= r_rmw_id;
                r_rsp_kind <= K_WRITE;
            end else if (w_gnt_any && !w_is_pwr) begin
                r_rsp_pend <= 1'b1;
                r_rsp_id   <= w_gnt_id;
                r_rsp_kind <= w_is_err ? K_ERR : (w_is_read ? K_READ : K_WRITE);
            end
        end
    end

    // Response outputs: read data comes straight from the macro's registered output.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        if (rst_n && r_rsp_pend) begin
            bus.rsp_valid[r_rsp_id] = 1'b1;
            if (r_rsp_kind == K_READ) begin
                bus.rsp_rdata = sram_rdata;
            end else if (r_rsp_kind == K_ERR) begin
                bus.rsp_err = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with behavioural SRAM macro
module tb_sram_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sram_web;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    always #5 clk = ~clk;

    sram_arbiter_if #(.NUM_REQ(N)) bus ();

    sram_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sram_web   (sram_web),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM macro: registered read, commits only when all WEB bits are low.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (sram_web == 4'h0) mem[sram_addr[15:2]] <= sram_wdata;
        sram_rdata <= mem[sram_addr[15:2]];
    end

    typedef struct {
        logic [3:0]  web;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    cmd_t        cq [N][$];
    exp_t        sb [$];
    logic [31:0] shadow [logic [13:0]];
    int          grant_log [$];
    int          grant_cyc [$];
    int          exp_g [$];
    bit          popme [N];
    bit          abort_mode = 1'b0;
    bit          mchk_on = 1'b0;
    int          mchk_cyc;
    logic [31:0] mchk_addr;
    logic [31:0] mchk_data;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a[15:2]) ? shadow[a[15:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] web);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = web[k] ? old[8*k +: 8] : wd[8*k +: 8];
        return r;
    endfunction

    function automatic int pending();
        int s = sb.size();
        for (int i = 0; i < N; i++) s += cq[i].size();
        return s;
    endfunction

    task automatic push_cmd(input int i, input logic [3:0] web, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic lock);
        cmd_t c;
        c.web = web; c.addr = addr; c.wdata = wdata; c.lock = lock;
        cq[i].push_back(c);
    endtask

    // Builds the expected response for a transfer and checks the SRAM port in the same cycle.
    task automatic model_xfer(input int i);
        exp_t        e;
        logic [3:0]  web;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] nw;
        web  = bus.req_web[i*4 +: 4];
        addr = bus.req_addr[i*32 +: 32];
        wd   = bus.req_wdata[i*32 +: 32];
        e.id = i; e.due = cyc + 1; e.data = 32'h0; e.err = 1'b0;
        if (addr[31:16] != 16'h0) begin
            e.err = 1'b1;
            check_eq("err_web", sram_web, 4'hF);
        end else if (web == 4'hF) begin
            e.data = shadow_rd(addr);
            check_eq("rd_web", sram_web, 4'hF);
            check_eq("rd_addr", sram_addr, {addr[31:2], 2'b00});
        end else if (web == 4'h0) begin
            shadow[addr[15:2]] = wd;
            check_eq("fw_web", sram_web, 4'h0);
            check_eq("fw_wdata", sram_wdata, wd);
        end else begin
            nw = merge_bytes(shadow_rd(addr), wd, web);
            shadow[addr[15:2]] = nw;
            mchk_on = 1'b1; mchk_cyc = cyc + 1;
            mchk_addr = {addr[31:2], 2'b00}; mchk_data = nw;
            e.due = cyc + 2;
            check_eq("pw_rd_web", sram_web, 4'hF);
            check_eq("pw_rd_addr", sram_addr, {addr[31:2], 2'b00});
        end
        sb.push_back(e);
    endtask

    task automatic check_grants(input string tag, input int span);
        check_eq({tag, "_ngrants"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check_eq({tag, "_grant"}, grant_log[i], exp_g[i]);
        if (grant_cyc.size() > 0)
            check_eq({tag, "_span"}, grant_cyc[grant_cyc.size()-1] - grant_cyc[0], span);
        grant_log.delete(); grant_cyc.delete(); exp_g.delete();
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (pending() > 0 && n < max_cyc) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_drain"}, n < max_cyc, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester drivers: hold each head command until it has been accepted.
    initial begin
        bus.req_valid = '0; bus.req_lock = '0; bus.req_web = '1;
        bus.req_addr = '0; bus.req_wdata = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (popme[i]) begin
                    popme[i] = 1'b0;
                    if (cq[i].size() > 0) cq[i].delete(0);
                end
                if (cq[i].size() > 0) begin
                    bus.req_valid[i]          = 1'b1;
                    bus.req_web[i*4 +: 4]     = cq[i][0].web;
                    bus.req_addr[i*32 +: 32]  = cq[i][0].addr;
                    bus.req_wdata[i*32 +: 32] = cq[i][0].wdata;
                    bus.req_lock[i]           = cq[i][0].lock;
                end else begin
                    bus.req_valid[i]          = 1'b0;
                    bus.req_web[i*4 +: 4]     = 4'hF;
                    bus.req_addr[i*32 +: 32]  = 32'h0;
                    bus.req_wdata[i*32 +: 32] = 32'h0;
                    bus.req_lock[i]           = 1'b0;
                end
            end
        end
    end

    // Monitor on the falling edge: reset values, merge cycle, responses, then new transfers.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_ready", bus.req_ready, 0);
            check_eq("rst_web", sram_web, 4'hF);
            check_eq("rst_addr", sram_addr, 0);
            check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 0);
        end else begin
            check_eq("ready_onehot", $countones(bus.req_ready) <= 1, 1);
            check_eq("ready_subset", bus.req_ready & ~bus.req_valid, 0);
            if (mchk_on && cyc == mchk_cyc) begin
                mchk_on = 1'b0;
                check_eq("mg_web", sram_web, 4'h0);
                check_eq("mg_addr", sram_addr, mchk_addr);
                check_eq("mg_wdata", sram_wdata, mchk_data);
                check_eq("mg_ready", bus.req_ready, 0);
            end
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_id", bus.rsp_valid, 64'(1) << e.id);
                    check_eq("rsp_rdata", bus.rsp_rdata, e.data);
                    check_eq("rsp_err", bus.rsp_err, e.err);
                    check_eq("rsp_cycle", cyc, e.due);
                end
            end else begin
                check_eq("rsp_idle", {bus.rsp_rdata, bus.rsp_err}, 0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check_eq("rsp_missing", sb[0].id + 100, sb[0].id);
                    sb.delete(0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    popme[i] = 1'b1;
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                    if (!abort_mode) model_xfer(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held with every requester valid; first grant after release goes to req 0.
        push_cmd(0, 4'h0, 32'h100, 32'hA0A0A0A0, 1'b0);
        push_cmd(1, 4'h0, 32'h104, 32'h0B0B0B0B, 1'b0);
        push_cmd(2, 4'h0, 32'h108, 32'h0C0C0C0C, 1'b0);
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle("reset", 50);
        exp_g = '{0, 1, 2};
        check_grants("reset", 2);

        // Full write then back-to-back read on req 0.
        push_cmd(0, 4'h0, 32'h100, 32'hDEADBEEF, 1'b0);
        push_cmd(0, 4'hF, 32'h100, 32'h0, 1'b0);
        wait_idle("wr_rd", 50);
        exp_g = '{0, 0};
        check_grants("wr_rd", 1);

        // Continuous reads from all requesters; pointer starts at 1 after req 0's last grant.
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++) push_cmd(i, 4'hF, 32'h100 + 32'(4*i), 32'h0, 1'b0);
        wait_idle("rr", 100);
        exp_g = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        check_grants("rr", 11);

        // Partial write with req 0 competing; MERGE blocks all grants for one cycle.
        push_cmd(1, 4'h0, 32'h40, 32'h11223344, 1'b0);
        push_cmd(1, 4'b1100, 32'h40, 32'hAABBCCDD, 1'b0);
        push_cmd(1, 4'hF, 32'h40, 32'h0, 1'b0);
        push_cmd(0, 4'hF, 32'h100, 32'h0, 1'b0);
        push_cmd(0, 4'hF, 32'h100, 32'h0, 1'b0);
        wait_idle("pw", 100);
        exp_g = '{1, 0, 1, 0, 1};
        check_grants("pw", 5);

        // Out-of-window read and write.
        push_cmd(2, 4'hF, 32'h0001_0000, 32'h0, 1'b0);
        push_cmd(2, 4'h0, 32'h0002_0040, 32'h12345678, 1'b0);
        push_cmd(2, 4'hF, 32'h40, 32'h0, 1'b0);
        wait_idle("err", 50);
        exp_g = '{2, 2, 2};
        check_grants("err", 2);

        // Lock: move the pointer to 2, then req 2 holds the bus while req 0 and 1 wait.
        push_cmd(1, 4'hF, 32'h104, 32'h0, 1'b0);
        wait_idle("pre_lock", 50);
        exp_g = '{1};
        check_grants("pre_lock", 0);
        push_cmd(2, 4'hF, 32'h100, 32'h0, 1'b1);
        push_cmd(2, 4'hF, 32'h104, 32'h0, 1'b1);
        push_cmd(2, 4'h0, 32'h108, 32'h55AA55AA, 1'b0);
        push_cmd(0, 4'hF, 32'h108, 32'h0, 1'b0);
        push_cmd(1, 4'hF, 32'h104, 32'h0, 1'b0);
        wait_idle("lock", 100);
        exp_g = '{2, 2, 2, 0, 1};
        check_grants("lock", 4);

        // Reset during MERGE: the RMW must leave memory untouched and give no response.
        abort_mode = 1'b1;
        push_cmd(1, 4'b0011, 32'h40, 32'hFFFFFFFF, 1'b0);
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_eq("abort_grant_seen", grant_log.size(), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        abort_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("abort_no_rsp", sb.size(), 0);
        grant_log.delete(); grant_cyc.delete();

        // After reset the pointer is back at 0; memory at 0x40 still holds the merged word.
        push_cmd(1, 4'hF, 32'h40, 32'h0, 1'b0);
        push_cmd(0, 4'hF, 32'h100, 32'h0, 1'b0);
        push_cmd(2, 4'hF, 32'h108, 32'h0, 1'b0);
        wait_idle("post_rst", 50);
        exp_g = '{0, 1, 2};
        check_grants("post_rst", 2);

        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
